// File: rtl/router_pkt_tx_if.sv
// Bus bundle between a packet loader/controller and the router packet source.
// The master side writes payload, issues launch commands and reports router
// backpressure; the slave side (the packet source) drives the router byte stream.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       buf_full;
    logic [6:0] buf_count;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pld_len;
    logic       inject_err;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       cmd_err;

    modport master (
        output wr_en, wr_data, start, dest_addr, pld_len, inject_err, busy,
        input  buf_full, buf_count, data_out, pkt_valid, tx_active, done, cmd_err
    );

    modport slave (
        input  wr_en, wr_data, start, dest_addr, pld_len, inject_err, busy,
        output buf_full, buf_count, data_out, pkt_valid, tx_active, done, cmd_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers payload bytes in a FIFO and, on a start
// command, serialises header, payload and parity bytes towards the router,
// holding the current byte whenever the router signals busy.
module router_pkt_tx #(
    parameter int DEPTH    = 64,
    parameter int IDLE_GAP = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    router_pkt_tx_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam int         GW       = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP);
    localparam logic [6:0] FULL_CNT = 7'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    // ------------------------------------------------------------------
    // Payload FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]    count_q, count_d;
    logic [7:0]    head_q;
    logic          full;
    logic          wr_accept;
    logic          pop;

    assign full      = (count_q == FULL_CNT);
    assign wr_accept = bus.wr_en && !full;

    // Next pointer/count values; a simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_accept ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 7'd1;
            2'b01:   count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Registered read of the head entry addressed by the next read pointer, so
    // head_q always holds the byte at rd_ptr_q. A byte written into the slot
    // that becomes the head (FIFO empty after this edge) is forwarded directly.
    always_ff @(posedge clk_i) begin
        if (wr_accept && (wr_ptr_q == rd_ptr_d)) begin
            head_q <= bus.wr_data;
        end else begin
            head_q <= mem[rd_ptr_d];
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [1:0]    addr_q, addr_d;
    logic [5:0]    len_q, len_d;
    logic          inj_q, inj_d;
    logic [5:0]    rem_q, rem_d;
    logic [7:0]    parity_q, parity_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;
    logic          cmd_err_q, cmd_err_d;
    logic [7:0]    data_out_c;
    logic          pkt_valid_c;
    logic          xfer;
    logic          cmd_ok;

    // A presented byte moves to the router on any edge where busy is low.
    assign xfer   = !bus.busy;
    assign cmd_ok = (bus.dest_addr != 2'd3) && (bus.pld_len != 6'd0) &&
                    ({1'b0, bus.pld_len} <= count_q);

    // Next-state, byte selection and FIFO pop for the current packet phase.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        inj_d       = inj_q;
        rem_d       = rem_q;
        parity_d    = parity_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        pop         = 1'b0;
        data_out_c  = 8'h00;
        pkt_valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cmd_ok) begin
                        state_d = S_HEADER;
                        addr_d  = bus.dest_addr;
                        len_d   = bus.pld_len;
                        inj_d   = bus.inject_err;
                        rem_d   = bus.pld_len;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            S_HEADER: begin
                data_out_c  = {len_q, addr_q};
                pkt_valid_c = 1'b1;
                parity_d    = {len_q, addr_q};
                if (xfer) begin
                    state_d = S_PAYLOAD;
                end
            end

            S_PAYLOAD: begin
                data_out_c  = head_q;
                pkt_valid_c = 1'b1;
                if (xfer) begin
                    parity_d = parity_q ^ head_q;
                    pop      = 1'b1;
                    rem_d    = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        state_d = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                data_out_c  = parity_q ^ {7'b0, inj_q};
                pkt_valid_c = 1'b0;
                if (xfer) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, latched command fields and status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            inj_q     <= 1'b0;
            rem_q     <= '0;
            parity_q  <= '0;
            gap_q     <= '0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            inj_q     <= inj_d;
            rem_q     <= rem_d;
            parity_q  <= parity_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign bus.data_out  = data_out_c;
    assign bus.pkt_valid = pkt_valid_c;
    assign bus.tx_active = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.buf_full  = full;
    assign bus.buf_count = count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: table-driven packet commands, a scoreboard of
// expected router bytes checked by a monitor, plus buffer-full and
// mid-packet reset sequences.
module tb_router_pkt_tx;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    router_pkt_tx_if u_if ();

    router_pkt_tx #(
        .DEPTH    (DEPTH),
        .IDLE_GAP (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic       inj;
        int         nload;
        bit         fixed;
        int         bmode;   // 0: no busy, 1: stall byte index 2 for 3 cycles, 2: random busy + writes
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    int         n_vec = 0;
    int         n_fail = 0;
    logic [7:0] m_fifo[$];
    exp_t       exp_q[$];
    bit         in_pkt = 0;
    bit         done_expect = 0;
    int         done_seen = 0;
    int         xfer_idx = 0;
    vec_t       tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic v);
        exp_t e;
        e.data  = d;
        e.valid = v;
        exp_q.push_back(e);
    endtask

    task automatic write_byte(input logic [7:0] b);
        u_if.wr_en   = 1'b1;
        u_if.wr_data = b;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
        step();
        u_if.wr_en = 1'b0;
    endtask

    // Monitor: every presented byte must match the scoreboard head; a byte is
    // retired when it is presented with busy low. done must follow the parity.
    always @(negedge clk) begin
        exp_t tmp;
        if (rst) begin
            exp_q.delete();
            in_pkt      = 0;
            done_expect = 0;
        end else begin
            if (done_expect) begin
                chk("done_pulse", {31'b0, u_if.done}, 32'd1);
                done_expect = 0;
                done_seen++;
            end else if (u_if.done) begin
                chk("done_spurious", {31'b0, u_if.done}, 32'd0);
            end
            if (u_if.tx_active && (u_if.pkt_valid || in_pkt)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL extra_byte: got %0h valid %0b, expected no byte", u_if.data_out, u_if.pkt_valid);
                end else begin
                    chk("byte", {23'b0, u_if.pkt_valid, u_if.data_out}, {23'b0, exp_q[0].valid, exp_q[0].data});
                    if (!u_if.busy) begin
                        tmp = exp_q.pop_front();
                        xfer_idx++;
                        if (tmp.valid) in_pkt = 1;
                        else begin
                            in_pkt      = 0;
                            done_expect = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic run_vec(input int id, input vec_t v);
        logic [7:0] b;
        logic [7:0] par;
        bit         acc;
        int         cyc;
        int         seen0;
        int         stall;
        for (int i = 0; i < v.nload; i++) begin
            b = v.fixed ? 8'((i + 1) * 17) : 8'($urandom);
            write_byte(b);
        end
        acc = (v.addr != 2'd3) && (v.len != 6'd0) && (m_fifo.size() >= int'(v.len));
        xfer_idx = 0;
        seen0    = done_seen;
        u_if.start      = 1'b1;
        u_if.dest_addr  = v.addr;
        u_if.pld_len    = v.len;
        u_if.inject_err = v.inj;
        if (acc) begin
            par = {v.len, v.addr};
            push_exp(par, 1'b1);
            for (int i = 0; i < int'(v.len); i++) begin
                b = m_fifo.pop_front();
                par ^= b;
                push_exp(b, 1'b1);
            end
            push_exp(par ^ {7'b0, v.inj}, 1'b0);
        end
        step();
        u_if.start      = 1'b0;
        u_if.dest_addr  = 2'd3;
        u_if.pld_len    = 6'd0;
        u_if.inject_err = 1'b0;
        if (!acc) begin
            @(negedge clk);
            chk("cmd_err_pulse", {31'b0, u_if.cmd_err}, 32'd1);
            chk("rej_pkt_valid", {31'b0, u_if.pkt_valid}, 32'd0);
            chk("rej_tx_active", {31'b0, u_if.tx_active}, 32'd0);
            @(negedge clk);
            chk("cmd_err_once", {31'b0, u_if.cmd_err}, 32'd0);
            chk("rej_buf_count", {25'b0, u_if.buf_count}, m_fifo.size());
            step();
            $display("vec %0d addr=%0d len=%0d inj=%0d -> rejected", id, v.addr, v.len, v.inj);
        end else begin
            stall = 0;
            cyc   = 0;
            while (done_seen == seen0 && cyc < 400) begin
                case (v.bmode)
                    1: begin
                        if (xfer_idx == 2 && stall < 3) begin
                            u_if.busy = 1'b1;
                            stall++;
                        end else u_if.busy = 1'b0;
                    end
                    2: u_if.busy = ($urandom_range(0, 2) == 0);
                    default: u_if.busy = 1'b0;
                endcase
                if (v.bmode == 2 && $urandom_range(0, 3) == 0 && m_fifo.size() < 8) begin
                    u_if.wr_en   = 1'b1;
                    u_if.wr_data = 8'($urandom);
                    m_fifo.push_back(u_if.wr_data);
                end else begin
                    u_if.wr_en = 1'b0;
                end
                step();
                cyc++;
            end
            u_if.busy  = 1'b0;
            u_if.wr_en = 1'b0;
            if (done_seen == seen0) begin
                n_vec++;
                n_fail++;
                $display("FAIL pkt_timeout: vec %0d got no done after %0d cycles, expected done", id, cyc);
            end
            @(negedge clk);
            chk("gap_active", {31'b0, u_if.tx_active}, 32'd1);
            @(negedge clk);
            chk("idle_after_gap", {31'b0, u_if.tx_active}, 32'd0);
            chk("post_buf_count", {25'b0, u_if.buf_count}, m_fifo.size());
            chk("bytes_left", exp_q.size(), 32'd0);
            step();
            $display("vec %0d addr=%0d len=%0d inj=%0d busy_mode=%0d -> sent in %0d cycles",
                     id, v.addr, v.len, v.inj, v.bmode, cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        tbl[0] = '{2'd1, 6'd3,  1'b0, 3,  1'b1, 0};
        tbl[1] = '{2'd1, 6'd3,  1'b0, 3,  1'b1, 1};
        tbl[2] = '{2'd1, 6'd3,  1'b1, 3,  1'b1, 0};
        tbl[3] = '{2'd3, 6'd3,  1'b0, 3,  1'b1, 0};
        tbl[4] = '{2'd0, 6'd0,  1'b0, 0,  1'b0, 0};
        tbl[5] = '{2'd2, 6'd5,  1'b0, 0,  1'b0, 0};
        tbl[6] = '{2'd2, 6'd7,  1'b0, 4,  1'b0, 2};
        tbl[7] = '{2'd0, 6'd1,  1'b0, 1,  1'b0, 2};
        tbl[8] = '{2'd2, 6'd20, 1'b1, 20, 1'b0, 2};
        tbl[9] = '{2'd1, 6'd2,  1'b0, 2,  1'b0, 0};

        u_if.wr_en      = 1'b0;
        u_if.wr_data    = 8'h00;
        u_if.start      = 1'b0;
        u_if.dest_addr  = 2'd0;
        u_if.pld_len    = 6'd0;
        u_if.inject_err = 1'b0;
        u_if.busy       = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_data_out",  {24'b0, u_if.data_out}, 32'd0);
        chk("rst_pkt_valid", {31'b0, u_if.pkt_valid}, 32'd0);
        chk("rst_tx_active", {31'b0, u_if.tx_active}, 32'd0);
        chk("rst_buf_count", {25'b0, u_if.buf_count}, 32'd0);
        chk("rst_buf_full",  {31'b0, u_if.buf_full}, 32'd0);
        chk("rst_done",      {31'b0, u_if.done}, 32'd0);
        chk("rst_cmd_err",   {31'b0, u_if.cmd_err}, 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

        // Fill past capacity: 64 bytes stored, the 65th dropped.
        for (int i = 0; i < 65; i++) begin
            write_byte(8'($urandom));
            if (i == 63) begin
                @(negedge clk);
                chk("full_at_64",  {31'b0, u_if.buf_full}, 32'd1);
                chk("count_at_64", {25'b0, u_if.buf_count}, 32'd64);
            end
        end
        @(negedge clk);
        chk("full_after_65",  {31'b0, u_if.buf_full}, 32'd1);
        chk("count_after_65", {25'b0, u_if.buf_count}, 32'd64);
        step();
        $display("fill: 65 writes issued, buf_count=%0d", u_if.buf_count);
        run_vec(10, '{2'd2, 6'd63, 1'b0, 0, 1'b0, 0});
        chk("drain_left", {25'b0, u_if.buf_count}, 32'd1);
        run_vec(11, '{2'd0, 6'd1, 1'b0, 0, 1'b0, 0});

        // Reset while the second payload byte is on the bus.
        for (int i = 0; i < 3; i++) write_byte(8'((i + 1) * 17));
        xfer_idx = 0;
        u_if.start     = 1'b1;
        u_if.dest_addr = 2'd1;
        u_if.pld_len   = 6'd3;
        push_exp(8'h0D, 1'b1);
        push_exp(8'h11, 1'b1);
        push_exp(8'h22, 1'b1);
        push_exp(8'h33, 1'b1);
        push_exp(8'h0D, 1'b0);
        m_fifo.delete();
        step();
        u_if.start = 1'b0;
        cyc = 0;
        while (xfer_idx < 2 && cyc < 50) begin
            step();
            cyc++;
        end
        if (xfer_idx < 2) begin
            n_vec++;
            n_fail++;
            $display("FAIL rst_seq_timeout: got %0d transfers, expected 2", xfer_idx);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_data_out",  {24'b0, u_if.data_out}, 32'd0);
        chk("arst_pkt_valid", {31'b0, u_if.pkt_valid}, 32'd0);
        chk("arst_tx_active", {31'b0, u_if.tx_active}, 32'd0);
        chk("arst_buf_count", {25'b0, u_if.buf_count}, 32'd0);
        chk("arst_flags",     {29'b0, u_if.buf_full, u_if.done, u_if.cmd_err}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        chk("post_rst_idle",  {31'b0, u_if.tx_active}, 32'd0);
        chk("post_rst_count", {25'b0, u_if.buf_count}, 32'd0);
        $display("reset mid-packet: outputs cleared, resuming");
        run_vec(12, tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the router input port. It buffers payload bytes written by a local loader and, on command, serialises one router packet onto data_out/pkt_valid:
- header byte = {length[5:0], addr[1:0]}, sent with pkt_valid=1;
- payload bytes, sent with pkt_valid=1;
- parity byte = XOR of header and all payload bytes, sent with pkt_valid=0.

It honours the router's busy backpressure and is the transmitting end of the interface whose receive side computes internal parity and flags err.

Parameters:
DEPTH, 64, payload buffer depth in bytes (power of two, at least 63).
IDLE_GAP, 2, idle cycles forced after each parity byte before the next header.

Ports:
clock  in  1  single clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
wr_en  in  1  write wr_data into payload buffer.
wr_data  in  8  payload byte.
buf_full  out  1  buffer holds DEPTH bytes; writes are ignored.
buf_count  out  7  bytes currently buffered.
start  in  1  one-cycle launch request.
dest_addr  in  2  destination port, 0..2; 3 is illegal.
pld_len  in  6  payload length, 1..63; 0 is illegal.
inject_err  in  1  sampled with start; corrupts the parity byte of that packet.
busy  in  1  router backpressure; while high the current byte must be held.
data_out  out  8  byte to router data_in.
pkt_valid  out  1  high for header and payload bytes, low for parity and idle.
tx_active  out  1  high from accepted start until the end of GAP.
done  out  1  one-cycle pulse on the edge the parity byte transfers.
cmd_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async, any state, including mid-packet):
  - FSM goes to IDLE; buffer pointers and count clear.
  - data_out=0, pkt_valid=0, tx_active=0, done=0, cmd_err=0, buf_full=0, buf_count=0.
- Buffer: synchronous FIFO.
  - Write accepted when wr_en && !buf_full.
  - Read happens on each payload byte transfer.
  - Simultaneous read and write: count unchanged, both take effect.
  - Write while full is dropped, with no error flag.
- Transfer rule: a presented byte transfers on a rising edge where busy=0. While busy=1, data_out and pkt_valid hold stable.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - data_out=0, pkt_valid=0.
  - start is accepted when dest_addr!=3, pld_len!=0 and buf_count>=pld_len; the FSM goes to HEADER on the next edge.
  - Otherwise start is rejected: cmd_err pulses the next cycle and the FSM stays in IDLE.
  - On acceptance, latch dest_addr, pld_len and inject_err; load the remaining-byte counter with pld_len.
  - start outside IDLE is ignored, with no cmd_err.
- HEADER:
  - data_out={len,addr}, pkt_valid=1.
  - Parity register is loaded with the header value.
  - On transfer: go to PAYLOAD and present the FIFO head byte.
- PAYLOAD:
  - data_out=FIFO head, pkt_valid=1.
  - On each transfer: parity ^= byte, pop FIFO, decrement counter.
  - After the last byte (counter 1→0) transfers: go to PARITY.
  - FIFO cannot underflow, since length was checked at start.
- PARITY:
  - data_out=parity (bit0 inverted when the latched inject_err is 1), pkt_valid=0.
  - On transfer: done pulses on that edge's following cycle; go to GAP.
- GAP:
  - data_out=0, pkt_valid=0 for IDLE_GAP cycles, then IDLE.
  - tx_active drops on entry to IDLE.
- Latency: accepted start → header on data_out after 1 cycle. Minimum packet time with busy=0 is pld_len+2 cycles plus IDLE_GAP.
- Loader writes are permitted during transmission; bytes beyond the current packet stay queued for the next packet.

Test Plan:
- Write 8'h11, 8'h22, 8'h33; start with addr=1, len=3; busy=0 → data_out sequence 8'h0D, 11, 22, 33 with pkt_valid=1, then 8'h0D with pkt_valid=0; done pulses; buf_count=0.
- Same packet with busy=1 for 3 cycles during byte 8'h22 → 8'h22 and pkt_valid held for 4 cycles; parity still 8'h0D; no byte duplicated or dropped.
- Same packet with inject_err=1 → parity byte 8'h0C; every other byte unchanged.
- start with addr=3, or with len=0, or with len=5 while buf_count=3 → cmd_err pulses once; pkt_valid stays 0; buffer untouched.
- Write 65 bytes → buf_full=1 and buf_count=64 after the 64th write; 65th byte dropped; a len=63 packet drains 63 bytes, leaving buf_count=1.
- Assert reset during the 2nd payload byte → all outputs 0 immediately; after release, state is IDLE with buf_count=0; a new packet transmits correctly.
